// File: rtl/udma_eth_frame_tx.sv
// uDMA-to-AXI-Stream Ethernet TX framer: unpacks 32-bit uDMA words into a byte stream
// of a programmed length, flagging the final byte with tlast.
module udma_eth_frame_tx #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 set_tx_bytes_i,
    input  logic [CNT_WIDTH-1:0] tx_bytes_i,
    input  logic                 abort_i,
    output logic [CNT_WIDTH-1:0] tx_bytes_left_o,
    output logic                 busy_o,

    input  logic [31:0]          data_tx_i,
    input  logic                 data_tx_valid_i,
    output logic                 data_tx_ready_o,

    output logic [7:0]           tx_axis_tdata_o,
    output logic                 tx_axis_tvalid_o,
    input  logic                 tx_axis_tready_i,
    output logic                 tx_axis_tlast_o
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StSend
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [31:0]          hold_q, hold_d;
    logic [1:0]           idx_q, idx_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            count_q <= '0;
            hold_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        if (abort_i) begin
            state_d = StIdle;
            count_d = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    count_d = '0;
                    if (set_tx_bytes_i && (tx_bytes_i != '0)) begin
                        count_d = tx_bytes_i;
                        state_d = StLoad;
                    end
                end
                StLoad: begin
                    if (data_tx_valid_i) begin
                        hold_d  = data_tx_i;
                        idx_d   = '0;
                        state_d = StSend;
                    end
                end
                StSend: begin
                    if (tx_axis_tready_i) begin
                        count_d = count_q - CNT_WIDTH'(1);
                        idx_d   = idx_q + 2'd1;
                        // Last byte wins over word exhaustion: upper bytes are dropped.
                        if (count_q == CNT_WIDTH'(1)) begin
                            state_d = StIdle;
                            idx_d   = '0;
                        end else if (idx_q == 2'd3) begin
                            state_d = StLoad;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    count_d = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    assign data_tx_ready_o  = (state_q == StLoad);
    assign tx_axis_tvalid_o = (state_q == StSend);
    assign tx_axis_tdata_o  = hold_q[{idx_q, 3'b000} +: 8];
    assign tx_axis_tlast_o  = (state_q == StSend) && (count_q == CNT_WIDTH'(1));
    assign tx_bytes_left_o  = count_q;
    assign busy_o           = (state_q != StIdle);

endmodule

// File: tb/tb_udma_eth_frame_tx.sv
// Self-checking bench for udma_eth_frame_tx: table-driven frames scored against a byte queue,
// plus hand-written sequences for zero length, busy set, abort and mid-frame reset.
module tb_udma_eth_frame_tx;

    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          set_tx_bytes;
    logic [CW-1:0] tx_bytes;
    logic          abort;
    logic [CW-1:0] tx_bytes_left;
    logic          busy;
    logic [31:0]   data_tx;
    logic          data_tx_valid;
    logic          data_tx_ready;
    logic [7:0]    tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;

    udma_eth_frame_tx #(.CNT_WIDTH(CW)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .set_tx_bytes_i   (set_tx_bytes),
        .tx_bytes_i       (tx_bytes),
        .abort_i          (abort),
        .tx_bytes_left_o  (tx_bytes_left),
        .busy_o           (busy),
        .data_tx_i        (data_tx),
        .data_tx_valid_i  (data_tx_valid),
        .data_tx_ready_o  (data_tx_ready),
        .tx_axis_tdata_o  (tdata),
        .tx_axis_tvalid_o (tvalid),
        .tx_axis_tready_i (tready),
        .tx_axis_tlast_o  (tlast)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned     len;
        logic [3:0][31:0] w;
        int              stall;
        int              xfers;
        int              span;   // expected last-handshake minus first-transfer cycle, -1 = skip
    } vec_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [8:0]  sb[$];          // {last, byte}
    logic [31:0] src_words[8];
    int          src_ptr = 0;
    int          word_xfers = 0;
    int          first_xfer_cyc = 0;
    int          last_hs_cyc = 0;
    int          hs_count = 0;
    int          stall_cfg = 0;
    int          wait_n = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // uDMA source: advances to the next word after each transfer.
    initial begin
        logic xfer;
        forever begin
            @(negedge clk);
            xfer = data_tx_valid && data_tx_ready;
            if (xfer && word_xfers == 0) first_xfer_cyc = cyc;
            @(posedge clk);
            #1;
            if (xfer) begin
                word_xfers++;
                if (src_ptr < 7) src_ptr++;
                data_tx = src_words[src_ptr];
            end
        end
    end

    // MAC sink: holds tready low for stall_cfg cycles on every presented byte.
    initial begin
        forever begin
            @(negedge clk);
            if (tvalid && tready) wait_n = 0;
            else if (tvalid) wait_n++;
            @(posedge clk);
            #1;
            tready = (wait_n >= stall_cfg);
        end
    end

    // Monitor: scores every handshake and checks tdata stability while stalled.
    initial begin
        logic       stalled = 1'b0;
        logic [7:0] held = '0;
        logic [8:0] exp;
        forever begin
            @(negedge clk);
            if (tvalid && stalled) check("tdata_stable", {56'd0, tdata}, {56'd0, held});
            if (tvalid && tready) begin
                hs_count++;
                if (tlast) last_hs_cyc = cyc;
                if (sb.size() == 0) begin
                    check("unexpected_byte", {55'd0, tlast, tdata}, 64'h1ff);
                end else begin
                    exp = sb.pop_front();
                    check("byte", {55'd0, tlast, tdata}, {55'd0, exp});
                end
                stalled = 1'b0;
            end else if (tvalid) begin
                stalled = 1'b1;
                held    = tdata;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input vec_t v);
        logic [31:0] word;
        for (int i = 0; i < 4; i++) src_words[i] = v.w[i];
        for (int i = 4; i < 8; i++) src_words[i] = 32'hDEAD_BEEF;
        src_ptr    = 0;
        data_tx    = src_words[0];
        word_xfers = 0;
        hs_count   = 0;
        stall_cfg  = v.stall;
        for (int i = 0; i < int'(v.len); i++) begin
            word = v.w[i / 4];
            sb.push_back({(i == int'(v.len) - 1), word[8 * (i % 4) +: 8]});
        end
        set_tx_bytes = 1'b1;
        tx_bytes     = v.len;
        cycle();
        set_tx_bytes = 1'b0;
        tx_bytes     = '0;
        check("busy_after_set", {63'd0, busy}, 64'd1);
        check("count_after_set", {32'd0, tx_bytes_left}, {32'd0, v.len});
    endtask

    task automatic finish_frame(input vec_t v);
        int n = 0;
        while ((busy || sb.size() != 0) && n < 500) begin
            cycle();
            n++;
        end
        check("frame_drained", {32'd0, 32'(sb.size())}, 64'd0);
        check("busy_after_frame", {63'd0, busy}, 64'd0);
        check("count_after_frame", {32'd0, tx_bytes_left}, 64'd0);
        check("word_xfers", {32'd0, 32'(word_xfers)}, {32'd0, 32'(v.xfers)});
        if (v.span >= 0)
            check("throughput_span", {32'd0, 32'(last_hs_cyc - first_xfer_cyc)},
                  {32'd0, 32'(v.span)});
    endtask

    initial begin
        vec_t tbl[5];
        vec_t v;
        int   n;

        tbl[0] = '{len: 6, w: {32'h0, 32'h0, 32'h88776655, 32'h44332211},
                   stall: 0, xfers: 2, span: -1};
        tbl[1] = '{len: 4, w: {32'h0, 32'h0, 32'h0, 32'hDDCCBBAA},
                   stall: 3, xfers: 1, span: -1};
        tbl[2] = '{len: 16, w: {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100},
                   stall: 0, xfers: 4, span: 19};
        tbl[3] = '{len: 1, w: {32'h0, 32'h0, 32'h0, 32'hFFEEDD5A},
                   stall: 0, xfers: 1, span: -1};
        tbl[4] = '{len: 7, w: {32'h0, 32'h0, 32'h77665544, 32'h332211F0},
                   stall: 1, xfers: 2, span: -1};

        rst           = 1'b1;
        set_tx_bytes  = 1'b0;
        tx_bytes      = '0;
        abort         = 1'b0;
        data_tx       = '0;
        data_tx_valid = 1'b1;
        tready        = 1'b1;
        cycle();
        cycle();
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_count", {32'd0, tx_bytes_left}, 64'd0);
        check("rst_ready", {63'd0, data_tx_ready}, 64'd0);
        check("rst_tvalid", {62'd0, tvalid, tlast}, 64'd0);
        rst = 1'b0;
        cycle();

        for (int i = 0; i < 5; i++) begin
            start_frame(tbl[i]);
            finish_frame(tbl[i]);
            cycle();
        end

        // Zero-length set is ignored.
        set_tx_bytes = 1'b1;
        tx_bytes     = '0;
        cycle();
        set_tx_bytes = 1'b0;
        check("zero_busy", {63'd0, busy}, 64'd0);
        check("zero_ready", {63'd0, data_tx_ready}, 64'd0);
        cycle();
        check("zero_count", {32'd0, tx_bytes_left}, 64'd0);

        // Abort and set in the same cycle: set is dropped.
        set_tx_bytes = 1'b1;
        tx_bytes     = 32'd5;
        abort        = 1'b1;
        cycle();
        set_tx_bytes = 1'b0;
        abort        = 1'b0;
        check("abort_set_busy", {63'd0, busy}, 64'd0);
        check("abort_set_count", {32'd0, tx_bytes_left}, 64'd0);

        // Set during SEND is ignored.
        v = '{len: 8, w: {32'h0, 32'h0, 32'h8877_6655, 32'h4433_2211}, stall: 0, xfers: 2, span: -1};
        start_frame(v);
        n = 0;
        while (!tvalid && n < 20) begin
            cycle();
            n++;
        end
        check("busy_set_in_send", {63'd0, tvalid}, 64'd1);
        set_tx_bytes = 1'b1;
        tx_bytes     = 32'd3;
        cycle();
        set_tx_bytes = 1'b0;
        tx_bytes     = '0;
        finish_frame(v);
        repeat (4) cycle();

        // Abort after 5 handshakes of a 10-byte frame.
        v = '{len: 10, w: {32'h0, 32'h2A29_2827, 32'h2625_2423, 32'h2221_201F}, stall: 0, xfers: 3,
              span: -1};
        start_frame(v);
        n = 0;
        while (hs_count < 5 && n < 50) begin
            cycle();
            n++;
        end
        check("abort_reached_5", {32'd0, 32'(hs_count)}, 64'd5);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        sb.delete();
        check("abort_tvalid", {62'd0, tvalid, tlast}, 64'd0);
        check("abort_count", {32'd0, tx_bytes_left}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        repeat (3) cycle();
        v = '{len: 1, w: {32'h0, 32'h0, 32'h0, 32'h5A5A_5A3C}, stall: 0, xfers: 1, span: -1};
        start_frame(v);
        finish_frame(v);
        repeat (2) cycle();

        // Reset mid-frame of a 12-byte frame.
        v = '{len: 12, w: {32'h0, 32'hBCBB_BAB9, 32'hB8B7_B6B5, 32'hB4B3_B2B1}, stall: 0, xfers: 3,
              span: -1};
        start_frame(v);
        n = 0;
        while (hs_count < 3 && n < 50) begin
            cycle();
            n++;
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        sb.delete();
        check("mid_rst_outputs", {58'd0, busy, data_tx_ready, tvalid, tlast, 2'b00}, 64'd0);
        check("mid_rst_count", {32'd0, tx_bytes_left}, 64'd0);
        check("mid_rst_tdata", {56'd0, tdata}, 64'd0);
        repeat (5) cycle();
        v = '{len: 2, w: {32'h0, 32'h0, 32'h0, 32'h0000_C3C2}, stall: 0, xfers: 1, span: -1};
        start_frame(v);
        finish_frame(v);
        repeat (3) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/udma_eth_frame_tx.md
UDMA_ETH_FRAME_TX -- requirements
Module: udma_eth_frame_tx

Interface
REQ-001: Parameter CNT_WIDTH, default 32, SHALL set the width of the frame byte counter.
REQ-002: clk_i  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-003: rst_i  in  1  SHALL be the synchronous, active-high reset.
REQ-004: set_tx_bytes_i  in  1  SHALL be a one-cycle pulse that starts a frame of tx_bytes_i bytes.
REQ-005: tx_bytes_i  in  CNT_WIDTH  SHALL carry the frame length in bytes, sampled with set_tx_bytes_i.
REQ-006: abort_i  in  1  SHALL be a one-cycle pulse that cancels the frame in progress.
REQ-007: tx_bytes_left_o  out  CNT_WIDTH  SHALL give the bytes not yet accepted by the MAC.
REQ-008: busy_o  out  1  SHALL be high whenever the FSM is not IDLE.
REQ-009: data_tx_i  in  32  SHALL carry a uDMA TX word; byte 0 is in bits [7:0].
REQ-010: data_tx_valid_i  in  1  SHALL mark data_tx_i as valid.
REQ-011: data_tx_ready_o  out  1  SHALL signal word acceptance; a transfer occurs when valid and ready are both high.
REQ-012: tx_axis_tdata_o  out  8  SHALL carry the byte to the Ethernet MAC.
REQ-013: tx_axis_tvalid_o  out  1  SHALL mark tx_axis_tdata_o as valid.
REQ-014: tx_axis_tready_i  in  1  SHALL be the MAC byte acceptance; a handshake occurs when tvalid and tready are both high.
REQ-015: tx_axis_tlast_o  out  1  SHALL mark the final byte of the frame.

Function
REQ-016: The FSM SHALL have states IDLE, LOAD and SEND.
REQ-017: In IDLE, set_tx_bytes_i with tx_bytes_i != 0 SHALL latch the count into tx_bytes_left_o and enter LOAD on the next edge.
REQ-018: In IDLE, set_tx_bytes_i with tx_bytes_i == 0 SHALL be ignored: state stays IDLE and tx_bytes_left_o stays 0.
REQ-019: set_tx_bytes_i outside IDLE SHALL be ignored; the count, state and stream are unaffected.
REQ-020: data_tx_ready_o SHALL equal (state == LOAD) and SHALL be combinational from the registered state only.
REQ-021: On a word transfer in LOAD, the word SHALL be stored in a 32-bit holding register, the byte index SHALL be set to 0, and the FSM SHALL enter SEND.
REQ-022: tx_axis_tvalid_o SHALL be high in SEND only, starting the cycle after the word transfer (one-cycle latency).
REQ-023: tx_axis_tdata_o SHALL be holding-register byte [index], and SHALL stay stable while tvalid is high and tready is low.
REQ-024: Each MAC handshake SHALL decrement tx_bytes_left_o by 1 and increment the byte index modulo 4.
REQ-025: tx_axis_tlast_o SHALL be high exactly when tvalid is high and tx_bytes_left_o == 1.
REQ-026: Handshake with tx_bytes_left_o == 1 SHALL move the FSM to IDLE.
  - Unused upper bytes of the last word are discarded.
  - No further word is requested.
REQ-027: Handshake on byte index 3 with tx_bytes_left_o > 1 SHALL move the FSM to LOAD.
REQ-028: Throughput SHALL be 4 bytes per 5 cycles when valid and tready are held high.
REQ-029: abort_i SHALL take priority over every other event and force the following on the next edge:
  - state = IDLE
  - tx_bytes_left_o = 0
  - tvalid = 0 and tlast = 0
  - byte index = 0
REQ-030: abort_i and set_tx_bytes_i in the same cycle SHALL result in IDLE with count 0; the set is dropped.
REQ-031: tx_bytes_left_o SHALL never underflow; it SHALL be held at 0 in IDLE.
REQ-032: busy_o SHALL be registered-state derived; it rises the cycle after an accepted set and falls the cycle after the tlast handshake.

Reset
REQ-033: When rst_i is high at a clock edge, the block SHALL return to its reset state on that edge. Reset state:
  - state = IDLE
  - tx_bytes_left_o = 0
  - holding register = 0, byte index = 0
  - data_tx_ready_o = 0, tx_axis_tvalid_o = 0, tx_axis_tlast_o = 0, busy_o = 0
REQ-034: Reset mid-frame SHALL discard the held word and remaining count with no further MAC handshake. The first set after reset release SHALL start a clean frame.

Verification
REQ-035: Frame of 6 bytes.
  - Stimulus: set with tx_bytes_i = 6; words 0x44332211, 0x88776655; tready held high.
  - Response: bytes 11,22,33,44,55,66; tlast on 66.
  - Response: tx_bytes_left_o steps 6 to 0; 77 and 88 never sent; exactly 2 word transfers.
REQ-036: Backpressure.
  - Stimulus: tx_bytes_i = 4, word 0xDDCCBBAA, tready low for 3 cycles on each byte.
  - Response: tdata holds each value while stalled; 4 handshakes; tlast on DD.
REQ-037: Zero length, then busy set.
  - Stimulus: set with tx_bytes_i = 0.
  - Response: busy_o stays 0 and no ready.
  - Stimulus: start tx_bytes_i = 8, then set tx_bytes_i = 3 during SEND.
  - Response: 8 bytes are sent and the second set is ignored.
REQ-038: Abort.
  - Stimulus: tx_bytes_i = 10, abort_i after 5 handshakes.
  - Response: next cycle tvalid = 0, tx_bytes_left_o = 0, busy_o = 0.
  - Response: a following 1-byte frame sends byte 0 of a fresh word with tlast.
REQ-039: Reset mid-frame.
  - Stimulus: rst_i for 1 cycle during SEND of a 12-byte frame.
  - Response: all outputs are at their reset values on the next cycle.
REQ-040: Throughput.
  - Stimulus: tx_bytes_i = 16, valid and tready held high.
  - Response: the frame completes in 20 cycles from the first word transfer.
